hall_sector_decoder: RTL and testbench
======================================

# hall_sector_decoder

Hall-sensor front end for the brushless driver. Synchronises and debounces the three raw hall inputs, maps them to a commutation sector 0..5, and reports direction, electrical period and rotating/fault status. Sits directly upstream of the commutation/gate-drive stage: its `sector` output replaces that stage's open-loop rotation counter once `rotating` is high.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required before a new hall code is accepted; legal values are 2 or more.
- `PERIOD_W`, default 22: width of the period timer and the `period` output.
- `STALL_CYCLES`, default 2_700_000: cycles with no edge before the motor is declared stalled (100 ms at 27 MHz). Must be less than 2^PERIOD_W − 1.
- `PHASE_OFFSET`, default 0: sector rotation, 0..5, applied modulo 6.

Ports:
- `clk` in 1: system clock. The block has a single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `hs` in 3: raw hall inputs, asynchronous to `clk`.
- `sector` out 3: current commutation sector, 0..5.
- `sector_valid` out 1: the current filtered hall code is legal.
- `edge_pulse` out 1: one-cycle pulse on each accepted transition between two legal codes.
- `dir` out 1: 1 = forward (sector increments), 0 = reverse.
- `period` out PERIOD_W: clk cycles between the last two adjacent-sector edges.
- `period_valid` out 1: `period` holds a true measurement.
- `rotating` out 1: motor is turning under hall feedback.
- `hall_fault` out 1: sticky; cleared only by `rst`.

## Operation
- **Synchronise:** `hs` passes through a 2-FF synchroniser into `hs_sync`.
- **Debounce:**
  - Candidate register plus counter. When `hs_sync` differs from the candidate, the candidate takes `hs_sync` and the counter clears.
  - Otherwise the counter increments, saturating.
  - When the counter reaches DEBOUNCE_CYCLES−1, `hs_filt` takes the candidate.
  - `hs_filt` resets to 3'b000.
- **Code map:** 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. Codes 000 and 111 are illegal.
  - `sector` = (map + PHASE_OFFSET) mod 6. Use a compare-and-subtract; no divider.
- **On a change of `hs_filt`:**
  - Legal → legal, new sector = old + 1 mod 6: `edge_pulse`; `dir`=1.
  - Legal → legal, new sector = old − 1 mod 6: `edge_pulse`; `dir`=0.
  - Legal → legal, any other jump: `edge_pulse`; `hall_fault`=1; `dir` holds; measurement restarts.
  - Any → illegal: `sector_valid`=0; `sector` holds its last value; `hall_fault`=1; measurement restarts.
  - Illegal → legal: `sector` updates and `sector_valid`=1. No `edge_pulse`, `dir` unchanged, measurement restarts.
- **Period timer:**
  - Clears to 0 in every `edge_pulse` cycle; otherwise increments, saturating at all-ones.
  - On an adjacent edge with `edge_cnt` ≥ 1: `period` ← timer + 1 (saturating), `period_valid`=1.
  - `edge_cnt` (2 bits, saturating) counts adjacent edges since the last restart.
  - A restart clears `edge_cnt` and `period_valid`; `period` holds its value.
- **Stall:** when the timer reaches STALL_CYCLES, `period_valid`=0, `rotating`=0 and `edge_cnt`=0.
- **Rotating:** `rotating` = `period_valid` & `sector_valid`, registered.
- **Reset values:** `sector` 0, `sector_valid` 0, `edge_pulse` 0, `dir` 1, `period` 0, `period_valid` 0, `rotating` 0, `hall_fault` 0; timer 0; all internal registers cleared.
  - `rst` mid-operation discards any pending candidate.
  - The first legal code after reset is handled as illegal → legal (no edge).

## Timing
- From a raw `hs` change (setup met) that is held stable, `sector`, `sector_valid` and `edge_pulse` update exactly DEBOUNCE_CYCLES + 3 cycles later: 2 synchroniser cycles, DEBOUNCE_CYCLES debounce cycles, 1 output register.
- `period`, `period_valid` and `dir` update in the same cycle as `edge_pulse`; `rotating` follows one cycle later.
- Hall pulses shorter than DEBOUNCE_CYCLES cycles are never seen at the outputs.
- A stall fires when the timer equals STALL_CYCLES, i.e. STALL_CYCLES cycles after the last edge.
- If an edge and the stall threshold occur in the same cycle, the edge wins and the stall does not fire.

## Structure
- Shared package `bldc_pkg`:
  - `typedef logic [2:0] sector_t`
  - `SECTOR_COUNT` = 6
  - constants `HALL_ILLEGAL_0` = 3'b000 and `HALL_ILLEGAL_7` = 3'b111
  - function `hall_to_sector`, mapping a hall code to a sector. The commutation stage reuses the package.
- Sub-module `hall_debounce`: 3-bit synchroniser plus debouncer, parameterised by DEBOUNCE_CYCLES, producing `hs_filt`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, STALL_CYCLES=1000, PERIOD_W=12.
1. Assert `rst`, then hold `hs`=001 → all outputs at their reset values; `sector`=0 and `sector_valid`=1 exactly 7 cycles after release; no `edge_pulse`.
2. Hold `hs`=001 steady, pulse 011 for 3 cycles, return to 001 → no output change, no `edge_pulse`.
3. Drive 001→011→010→110→100, each held 200 cycles → `edge_pulse` on each change; `dir`=1; from the second edge `period`=200 and `period_valid`=1; `rotating`=1 one cycle later.
4. Drive the reverse sequence 101→100→110, 200 cycles each → `dir`=0; `sector` follows 5,4,3; `period`=200.
5. While rotating, drive `hs`=111 → `sector_valid`=0, `sector` holds, `hall_fault`=1 and stays 1 after a return to legal codes. Separately, after reset, a skip 001→010 → `hall_fault`=1 and `period_valid`=0.
6. While rotating, freeze `hs` → `rotating`=0 and `period_valid`=0 exactly 1000 cycles after the last `edge_pulse`; `period` retains its last value.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: sector type, hall code constants and hall-to-sector map.
// Also used by the commutation stage.
package bldc_pkg;

  typedef logic [2:0] sector_t;

  localparam int unsigned SECTOR_COUNT = 6;

  localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
  localparam logic [2:0] HALL_ILLEGAL_7 = 3'b111;

  // Classification of a change in the filtered hall code.
  typedef enum logic [2:0] {
    TR_NONE,
    TR_FWD,
    TR_REV,
    TR_JUMP,
    TR_TO_ILLEGAL,
    TR_FROM_ILLEGAL
  } hall_tr_e;

  function automatic logic hall_legal(input logic [2:0] code);
    return (code != HALL_ILLEGAL_0) && (code != HALL_ILLEGAL_7);
  endfunction

  // Illegal codes map to 0; callers gate the result with hall_legal().
  function automatic sector_t hall_to_sector(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/hall_sector_decoder_if.sv
// Hall input and decoded sector/speed status bundle.
interface hall_sector_decoder_if #(
  parameter int unsigned PERIOD_W = 22
);
  import bldc_pkg::*;

  logic [2:0]          hs;
  sector_t             sector;
  logic                sector_valid;
  logic                edge_pulse;
  logic                dir;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                rotating;
  logic                hall_fault;

  modport master (
    input  hs,
    output sector, sector_valid, edge_pulse, dir,
    output period, period_valid, rotating, hall_fault
  );

  modport slave (
    output hs,
    input  sector, sector_valid, edge_pulse, dir,
    input  period, period_valid, rotating, hall_fault
  );

endinterface

// File: rtl/hall_debounce.sv
// 2-FF synchroniser plus stability filter for the three hall inputs.
module hall_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hs,
  output logic [2:0] hs_filt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);

  logic [2:0]    hs_meta;
  logic [2:0]    hs_sync;
  logic [2:0]    cand;
  logic [CW-1:0] cnt;

  // hs_filt is loaded on the edge where cnt steps to DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_meta <= '0;
      hs_sync <= '0;
      cand    <= '0;
      cnt     <= '0;
      hs_filt <= '0;
    end else begin
      hs_meta <= hs;
      hs_sync <= hs_meta;
      if (hs_sync != cand) begin
        cand <= hs_sync;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        if (cnt == CNT_LOAD) hs_filt <= cand;
      end
    end
  end

endmodule

// File: rtl/hall_sector_decoder.sv
// Hall front end: debounced hall code to commutation sector, direction,
// electrical period and rotating/fault status.
module hall_sector_decoder
  import bldc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PERIOD_W        = 22,
  parameter int unsigned STALL_CYCLES    = 2_700_000,
  parameter int unsigned PHASE_OFFSET    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  hall_sector_decoder_if.master hall
);

  localparam int unsigned OFFSET_M = PHASE_OFFSET % SECTOR_COUNT;
  localparam logic [PERIOD_W-1:0] STALL_PRE = PERIOD_W'(STALL_CYCLES - 1);

  logic [2:0]          hs_filt, filt_q;
  sector_t             sector_q, new_sector, sec_inc, sec_dec;
  logic [3:0]          sum;
  logic                sector_valid_q, edge_pulse_q, dir_q, period_valid_q;
  logic                rotating_q, hall_fault_q;
  logic [PERIOD_W-1:0] timer, period_q, timer_inc;
  logic [1:0]          edge_cnt;
  hall_tr_e            tr;
  logic                edge_n, stall;

  hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .hs      (hall.hs),
    .hs_filt (hs_filt)
  );

  always_comb begin
    sum        = {1'b0, hall_to_sector(hs_filt)} + 4'(OFFSET_M);
    new_sector = (sum >= 4'(SECTOR_COUNT)) ? 3'(sum - 4'(SECTOR_COUNT)) : sum[2:0];
    sec_inc    = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    sec_dec    = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
    timer_inc  = (timer == '1) ? timer : timer + PERIOD_W'(1);

    tr = TR_NONE;
    if (hs_filt != filt_q) begin
      if (!hall_legal(hs_filt))     tr = TR_TO_ILLEGAL;
      else if (!hall_legal(filt_q)) tr = TR_FROM_ILLEGAL;
      else if (new_sector == sec_inc) tr = TR_FWD;
      else if (new_sector == sec_dec) tr = TR_REV;
      else                            tr = TR_JUMP;
    end

    edge_n = (tr == TR_FWD) || (tr == TR_REV) || (tr == TR_JUMP);
    // An edge in the threshold cycle suppresses the stall.
    stall  = !edge_n && (timer == STALL_PRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q         <= '0;
      sector_q       <= '0;
      sector_valid_q <= 1'b0;
      edge_pulse_q   <= 1'b0;
      dir_q          <= 1'b1;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      rotating_q     <= 1'b0;
      hall_fault_q   <= 1'b0;
      timer          <= '0;
      edge_cnt       <= '0;
    end else begin
      filt_q       <= hs_filt;
      edge_pulse_q <= edge_n;
      timer        <= edge_n ? '0 : timer_inc;
      rotating_q   <= period_valid_q & sector_valid_q;

      case (tr)
        TR_FWD, TR_REV: begin
          sector_q <= new_sector;
          dir_q    <= (tr == TR_FWD);
          if (edge_cnt != 2'b11) edge_cnt <= edge_cnt + 2'd1;
          if (edge_cnt != 2'b00) begin
            period_q       <= timer_inc;
            period_valid_q <= 1'b1;
          end
        end
        TR_JUMP: begin
          sector_q       <= new_sector;
          hall_fault_q   <= 1'b1;
          edge_cnt       <= '0;
          period_valid_q <= 1'b0;
        end
        TR_TO_ILLEGAL: begin
          sector_valid_q <= 1'b0;
          hall_fault_q   <= 1'b1;
          edge_cnt       <= '0;
          period_valid_q <= 1'b0;
        end
        TR_FROM_ILLEGAL: begin
          sector_q       <= new_sector;
          sector_valid_q <= 1'b1;
          edge_cnt       <= '0;
          period_valid_q <= 1'b0;
        end
        default: ;
      endcase

      if (stall) begin
        period_valid_q <= 1'b0;
        rotating_q     <= 1'b0;
        edge_cnt       <= '0;
      end
    end
  end

  assign hall.sector       = sector_q;
  assign hall.sector_valid = sector_valid_q;
  assign hall.edge_pulse   = edge_pulse_q;
  assign hall.dir          = dir_q;
  assign hall.period       = period_q;
  assign hall.period_valid = period_valid_q;
  assign hall.rotating     = rotating_q;
  assign hall.hall_fault   = hall_fault_q;

endmodule

// File: tb/tb_hall_sector_decoder.sv
// Directed bench for hall_sector_decoder with DEBOUNCE_CYCLES=4, STALL_CYCLES=1000, PERIOD_W=12.
module tb_hall_sector_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses   = 0;

  always #5 clk = ~clk;

  hall_sector_decoder_if #(.PERIOD_W(12)) bus ();

  hall_sector_decoder #(
    .DEBOUNCE_CYCLES (4),
    .PERIOD_W        (12),
    .STALL_CYCLES    (1000),
    .PHASE_OFFSET    (0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .hall (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks, sampling 1 ns after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.edge_pulse) pulses++;
    end
  endtask

  // Drive a new hall code and verify the edge lands exactly 7 cycles later.
  task automatic drive_edge(input logic [2:0] code, input logic [2:0] exp_sector,
                            input logic exp_dir, input logic exp_pv,
                            input logic [11:0] exp_period, input int hold);
    bus.hs = code;
    step(6);
    check("edge_early", bus.edge_pulse, 1'b0);
    step(1);
    check("edge_pulse", bus.edge_pulse, 1'b1);
    check("edge_sector", bus.sector, exp_sector);
    check("edge_dir", bus.dir, exp_dir);
    check("edge_pv", bus.period_valid, exp_pv);
    check("edge_period", bus.period, exp_period);
    step(1);
    check("edge_width", bus.edge_pulse, 1'b0);
    check("rotating", bus.rotating, exp_pv);
    step(hold - 8);
  endtask

  initial begin
    bus.hs = 3'b001;

    // Reset values and first legal code after release
    step(3);
    check("rst_sector", bus.sector, 3'd0);
    check("rst_sv", bus.sector_valid, 1'b0);
    check("rst_edge", bus.edge_pulse, 1'b0);
    check("rst_dir", bus.dir, 1'b1);
    check("rst_period", bus.period, 12'd0);
    check("rst_pv", bus.period_valid, 1'b0);
    check("rst_rot", bus.rotating, 1'b0);
    check("rst_fault", bus.hall_fault, 1'b0);
    rst    = 1'b0;
    pulses = 0;
    step(6);
    check("first_sv_early", bus.sector_valid, 1'b0);
    step(1);
    check("first_sv", bus.sector_valid, 1'b1);
    check("first_sector", bus.sector, 3'd0);
    check("first_no_edge", pulses, 0);

    // Short glitch is rejected
    step(10);
    bus.hs = 3'b011;
    step(3);
    bus.hs = 3'b001;
    step(20);
    check("glitch_sector", bus.sector, 3'd0);
    check("glitch_sv", bus.sector_valid, 1'b1);
    check("glitch_edges", pulses, 0);
    check("glitch_fault", bus.hall_fault, 1'b0);

    // Forward rotation, 200 cycles per sector
    drive_edge(3'b011, 3'd1, 1'b1, 1'b0, 12'd0,   200);
    drive_edge(3'b010, 3'd2, 1'b1, 1'b1, 12'd200, 200);
    drive_edge(3'b110, 3'd3, 1'b1, 1'b1, 12'd200, 200);
    drive_edge(3'b100, 3'd4, 1'b1, 1'b1, 12'd200, 200);

    // 4 -> 5 is still forward; then reverse 5 -> 4 -> 3
    drive_edge(3'b101, 3'd5, 1'b1, 1'b1, 12'd200, 200);
    drive_edge(3'b100, 3'd4, 1'b0, 1'b1, 12'd200, 200);
    drive_edge(3'b110, 3'd3, 1'b0, 1'b1, 12'd200, 8);

    // Stall exactly 1000 cycles after the last edge_pulse
    step(998);
    check("stall_pv_early", bus.period_valid, 1'b1);
    check("stall_rot_early", bus.rotating, 1'b1);
    step(1);
    check("stall_pv", bus.period_valid, 1'b0);
    check("stall_rot", bus.rotating, 1'b0);
    check("stall_period", bus.period, 12'd200);
    check("stall_sector", bus.sector, 3'd3);
    check("stall_fault", bus.hall_fault, 1'b0);

    // Spin up again, then an illegal code while rotating
    drive_edge(3'b100, 3'd4, 1'b1, 1'b0, 12'd200, 200);
    drive_edge(3'b101, 3'd5, 1'b1, 1'b1, 12'd200, 20);
    bus.hs = 3'b111;
    step(6);
    check("ill_sv_early", bus.sector_valid, 1'b1);
    step(1);
    check("ill_sv", bus.sector_valid, 1'b0);
    check("ill_sector", bus.sector, 3'd5);
    check("ill_fault", bus.hall_fault, 1'b1);
    check("ill_edge", bus.edge_pulse, 1'b0);
    step(1);
    check("ill_rot", bus.rotating, 1'b0);
    bus.hs = 3'b101;
    pulses = 0;
    step(7);
    check("relegal_sv", bus.sector_valid, 1'b1);
    check("relegal_sector", bus.sector, 3'd5);
    check("relegal_fault", bus.hall_fault, 1'b1);
    check("relegal_pv", bus.period_valid, 1'b0);
    check("relegal_edges", pulses, 0);

    // Non-adjacent jump after a fresh reset
    rst    = 1'b1;
    bus.hs = 3'b001;
    step(2);
    check("rst2_fault", bus.hall_fault, 1'b0);
    rst = 1'b0;
    step(7);
    check("rst2_sector", bus.sector, 3'd0);
    step(10);
    bus.hs = 3'b010;
    step(7);
    check("jump_edge", bus.edge_pulse, 1'b1);
    check("jump_sector", bus.sector, 3'd2);
    check("jump_fault", bus.hall_fault, 1'b1);
    check("jump_pv", bus.period_valid, 1'b0);
    check("jump_dir", bus.dir, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
